// File: rtl/fpdiv_op_sequencer_if.sv
// Handshake and data bundle between the fpdiv operand sequencer, its producer,
// the fpdiv divider and the result consumer.
interface fpdiv_op_sequencer_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_a;
  logic [31:0]              in_b;
  logic [31:0]              div_a;
  logic [31:0]              div_b;
  logic                     div_start;
  logic [31:0]              div_result;
  logic                     div_done;
  logic [1:0]               div_exc;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_result;
  logic [1:0]               out_exc;
  logic                     out_timeout;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    input  in_valid, in_a, in_b, div_result, div_done, div_exc, out_ready,
    output in_ready, div_a, div_b, div_start, out_valid, out_result, out_exc,
           out_timeout, occupancy
  );

  modport slave (
    output in_valid, in_a, in_b, div_result, div_done, div_exc, out_ready,
    input  in_ready, div_a, div_b, div_start, out_valid, out_result, out_exc,
           out_timeout, occupancy
  );
endinterface

// File: rtl/fpdiv_op_sequencer.sv
// Operand FIFO plus single-outstanding issue FSM in front of the fpdiv divider,
// with a held result register and a watchdog that turns a hung divide into a NaN.
module fpdiv_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  fpdiv_op_sequencer_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state;
  state_t             next_state;

  logic [31:0]        mem_a [DEPTH];
  logic [31:0]        mem_b [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [TMR_W-1:0]   timer;

  logic               push;
  logic               pop;
  logic               load_div;
  logic               take_div;
  logic               take_wd;
  logic               release_out;
  logic               timer_hit;

  logic [31:0]        div_a_q;
  logic [31:0]        div_b_q;
  logic               div_start_q;
  logic               out_valid_q;
  logic [31:0]        out_result_q;
  logic [1:0]         out_exc_q;
  logic               out_timeout_q;

  assign bus.in_ready    = (count < CNT_W'(DEPTH));
  assign bus.occupancy   = count;
  assign bus.div_a       = div_a_q;
  assign bus.div_b       = div_b_q;
  assign bus.div_start   = div_start_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_exc     = out_exc_q;
  assign bus.out_timeout = out_timeout_q;

  assign push      = bus.in_valid & bus.in_ready;
  assign timer_hit = (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // The head is loaded into div_a/div_b on the way into ISSUE so it is valid
  // alongside div_start; the entry itself is retired at the end of ISSUE.
  always_comb begin
    next_state  = state;
    load_div    = 1'b0;
    pop         = 1'b0;
    take_div    = 1'b0;
    take_wd     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load_div   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        pop        = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (bus.div_done) begin
          take_div   = 1'b1;
          next_state = HOLD;
        end else if (timer_hit) begin
          take_wd    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          release_out = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div_a_q       <= '0;
      div_b_q       <= '0;
      div_start_q   <= 1'b0;
      timer         <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_exc_q     <= 2'b00;
      out_timeout_q <= 1'b0;
    end else begin
      div_start_q <= load_div;
      if (load_div) begin
        div_a_q <= mem_a[rd_ptr];
        div_b_q <= mem_b[rd_ptr];
      end

      if (pop)                timer <= '0;
      else if (state == WAIT) timer <= timer + TMR_W'(1);

      // A real divider result always beats the watchdog in the same cycle.
      if (take_div) begin
        out_result_q  <= bus.div_result;
        out_exc_q     <= bus.div_exc;
        out_timeout_q <= 1'b0;
        out_valid_q   <= 1'b1;
      end else if (take_wd) begin
        out_result_q  <= QNAN;
        out_exc_q     <= 2'b11;
        out_timeout_q <= 1'b1;
        out_valid_q   <= 1'b1;
      end else if (release_out) begin
        out_valid_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpdiv_op_sequencer.sv
// Directed bench for fpdiv_op_sequencer: the divider is played by hand-timed
// div_done pulses and every expected value below is a hand-computed constant.
module tb_fpdiv_op_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic CLOCK;
  logic RESET;

  int vectors     = 0;
  int miscompares = 0;
  int start_count = 0;
  int saved_starts;

  // Real IEEE-754 quotients: 1/0.5, 2/0.25, 3/-1, 0/0 (invalid), 5/10
  logic [31:0] pa  [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h00000000, 32'h40A00000};
  logic [31:0] pb  [5] = '{32'h3F000000, 32'h3E800000, 32'hBF800000, 32'h00000000, 32'h41200000};
  logic [31:0] res [5] = '{32'h40000000, 32'h41000000, 32'hC0400000, 32'h7FC00000, 32'h3F000000};
  logic [1:0]  exc [5] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00};

  localparam logic [31:0] R1 = 32'h4E1AC2A1;

  fpdiv_op_sequencer_if #(.DEPTH(DEPTH)) sif ();

  fpdiv_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (sif.master)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) if (sif.div_start === 1'b1) start_count++;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    sif.in_valid = 1'b1;
    sif.in_a     = a;
    sif.in_b     = b;
    tick();
    sif.in_valid = 1'b0;
  endtask

  task automatic waitForStart(input int budget);
    int n = 0;
    while (sif.div_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("start_seen", 32'(sif.div_start), 32'd1);
  endtask

  initial begin
    RESET          = 1'b1;
    sif.in_valid   = 1'b0;
    sif.in_a       = '0;
    sif.in_b       = '0;
    sif.div_result = '0;
    sif.div_done   = 1'b0;
    sif.div_exc    = 2'b00;
    sif.out_ready  = 1'b0;
    tick();
    tick();
    checkOutput("rst_occupancy", 32'(sif.occupancy), 32'd0);
    checkOutput("rst_out_valid", 32'(sif.out_valid), 32'd0);
    checkOutput("rst_div_start", 32'(sif.div_start), 32'd0);
    checkOutput("rst_div_a", sif.div_a, 32'd0);
    checkOutput("rst_out_result", sif.out_result, 32'd0);
    checkOutput("rst_out_exc", 32'(sif.out_exc), 32'd0);
    checkOutput("rst_out_timeout", 32'(sif.out_timeout), 32'd0);
    checkOutput("rst_in_ready", 32'(sif.in_ready), 32'd1);
    RESET = 1'b0;
    tick();

    $display("[TB] single op");
    applyStimulus(32'h48B3A37A, 32'h3A1493F6);
    checkOutput("t1_occ_after_push", 32'(sif.occupancy), 32'd1);
    checkOutput("t1_no_start_yet", 32'(sif.div_start), 32'd0);
    tick();
    checkOutput("t1_start", 32'(sif.div_start), 32'd1);
    checkOutput("t1_div_a", sif.div_a, 32'h48B3A37A);
    checkOutput("t1_div_b", sif.div_b, 32'h3A1493F6);
    tick();
    checkOutput("t1_start_pulse", 32'(sif.div_start), 32'd0);
    checkOutput("t1_occ_popped", 32'(sif.occupancy), 32'd0);
    repeat (8) tick();
    checkOutput("t1_not_valid_yet", 32'(sif.out_valid), 32'd0);
    sif.div_done   = 1'b1;
    sif.div_result = R1;
    sif.div_exc    = 2'b00;
    tick();
    sif.div_done = 1'b0;
    checkOutput("t1_out_valid", 32'(sif.out_valid), 32'd1);
    checkOutput("t1_out_result", sif.out_result, R1);
    checkOutput("t1_out_timeout", 32'(sif.out_timeout), 32'd0);
    checkOutput("t1_start_count", 32'(start_count), 32'd1);

    $display("[TB] fill while holding result, then backpressure");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pa[i], pb[i]);
      checkOutput("t2_occ_fill", 32'(sif.occupancy), 32'(i + 1));
    end
    checkOutput("t2_in_ready_full", 32'(sif.in_ready), 32'd0);
    sif.in_valid = 1'b1;
    sif.in_a     = pa[4];
    sif.in_b     = pb[4];
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t4_hold_result", sif.out_result, R1);
      checkOutput("t4_hold_valid", 32'(sif.out_valid), 32'd1);
      checkOutput("t4_no_issue", 32'(start_count), 32'd1);
    end
    checkOutput("t2_occ_still_full", 32'(sif.occupancy), 32'd4);
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    checkOutput("t4_released", 32'(sif.out_valid), 32'd0);
    checkOutput("t4_no_start_in_idle", 32'(sif.div_start), 32'd0);
    tick();
    checkOutput("t2_issue0_start", 32'(sif.div_start), 32'd1);
    checkOutput("t2_issue0_a", sif.div_a, pa[0]);
    checkOutput("t2_issue0_b", sif.div_b, pb[0]);
    checkOutput("t2_occ_before_pop", 32'(sif.occupancy), 32'd4);
    tick();
    checkOutput("t2_occ_after_pop", 32'(sif.occupancy), 32'd3);
    checkOutput("t2_in_ready_after_pop", 32'(sif.in_ready), 32'd1);
    tick();
    sif.in_valid = 1'b0;
    checkOutput("t2_occ_fifth", 32'(sif.occupancy), 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        waitForStart(8);
        checkOutput("t2_order_a", sif.div_a, pa[i]);
        checkOutput("t2_order_b", sif.div_b, pb[i]);
        tick();
      end
      sif.div_done   = 1'b1;
      sif.div_result = res[i];
      sif.div_exc    = exc[i];
      tick();
      sif.div_done = 1'b0;
      checkOutput("t2_res_valid", 32'(sif.out_valid), 32'd1);
      checkOutput("t2_res_value", sif.out_result, res[i]);
      checkOutput("t2_res_exc", 32'(sif.out_exc), 32'(exc[i]));
      checkOutput("t2_res_timeout", 32'(sif.out_timeout), 32'd0);
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
    end
    checkOutput("t2_total_starts", 32'(start_count), 32'd6);
    checkOutput("t2_drained", 32'(sif.occupancy), 32'd0);

    $display("[TB] hung divider");
    applyStimulus(32'h40490FDB, 32'h402DF854);
    waitForStart(4);
    repeat (TIMEOUT) tick();
    checkOutput("t3_not_yet", 32'(sif.out_valid), 32'd0);
    tick();
    checkOutput("t3_valid", 32'(sif.out_valid), 32'd1);
    checkOutput("t3_result", sif.out_result, 32'h7FC00000);
    checkOutput("t3_exc", 32'(sif.out_exc), 32'd3);
    checkOutput("t3_timeout", 32'(sif.out_timeout), 32'd1);
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;

    $display("[TB] done/watchdog race");
    applyStimulus(32'h40800000, 32'h40800000);
    waitForStart(4);
    repeat (TIMEOUT) tick();
    sif.div_done   = 1'b1;
    sif.div_result = 32'h3F800000;
    sif.div_exc    = 2'b00;
    tick();
    sif.div_done = 1'b0;
    checkOutput("t5_valid", 32'(sif.out_valid), 32'd1);
    checkOutput("t5_result", sif.out_result, 32'h3F800000);
    checkOutput("t5_exc", 32'(sif.out_exc), 32'd0);
    checkOutput("t5_timeout", 32'(sif.out_timeout), 32'd0);
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;

    $display("[TB] reset mid-op");
    applyStimulus(32'h41000000, 32'h40000000);
    waitForStart(4);
    applyStimulus(pa[0], pb[0]);
    applyStimulus(pa[1], pb[1]);
    applyStimulus(pa[2], pb[2]);
    checkOutput("t6_queued", 32'(sif.occupancy), 32'd3);
    RESET = 1'b1;
    tick();
    checkOutput("t6_rst_occ", 32'(sif.occupancy), 32'd0);
    checkOutput("t6_rst_valid", 32'(sif.out_valid), 32'd0);
    checkOutput("t6_rst_start", 32'(sif.div_start), 32'd0);
    checkOutput("t6_rst_div_a", sif.div_a, 32'd0);
    checkOutput("t6_rst_result", sif.out_result, 32'd0);
    RESET = 1'b0;
    saved_starts = start_count;
    sif.div_done   = 1'b1;
    sif.div_result = 32'hDEADBEEF;
    sif.div_exc    = 2'b11;
    tick();
    sif.div_done = 1'b0;
    checkOutput("t6_stale_valid", 32'(sif.out_valid), 32'd0);
    checkOutput("t6_stale_result", sif.out_result, 32'd0);
    repeat (10) tick();
    checkOutput("t6_no_start", 32'(start_count), 32'(saved_starts));
    checkOutput("t6_idle_occ", 32'(sif.occupancy), 32'd0);
    checkOutput("t6_idle_valid", 32'(sif.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
